irq_sequencer: RTL and testbench
================================

# irq_sequencer

Trap sequencer for the 5-stage pipelined CPU. It accepts the external interrupt request and the ID-stage illegal-instruction flag, and waits for a safe pipeline point. In a single trap cycle it flushes IF/ID and ID/EX, overrides the next PC with the handler vector, and writes the return address into the exception register. It then masks further traps until the handler returns to user mode (PC[31] falls).

## Interface
Parameters:
- ILLOP_ADDR, 32'h80000004, interrupt handler vector
- XADR_ADDR, 32'h80000008, exception handler vector
- XP_REG, 5'd26, register index receiving the return address
- CNT_W, 16, width of trap counters

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  1  level interrupt request from peripheral block
- undef_id  in  1  ID-stage opcode/funct is undefined
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_pc_plus_4  in  32  PC+4 of the ID instruction
- ex_valid  in  1  EX holds a real instruction
- ex_pc_plus_4  in  32  PC+4 of the EX instruction
- ex_redirect  in  1  EX is taking a branch/jump/jr this cycle
- load_use_stall  in  1  hazard unit is stalling PC and IF/ID this cycle
- pc_kernel  in  1  PC[31] of the fetch PC
- flush_if_id, flush_id_ex  out  1 each  squash those pipeline registers at next edge
- pc_override  out  1  PC_next := pc_override_addr
- pc_override_addr  out  32  handler vector
- xp_wr  out  1  register-file write request for XP_REG
- xp_addr  out  5  always XP_REG
- xp_data  out  32  return address
- busy  out  1  state != IDLE
- irq_cnt, exc_cnt  out  CNT_W each  saturating count of traps taken

## Operation
- States: IDLE, PEND (interrupt latched, waiting for safe point), KERNEL (handler running, traps masked).
- irq_q: irq_in registered once. It is the only irq input used.
- Exception condition: undef_id & id_valid & ~ex_redirect & ~pc_kernel & state != KERNEL. A wrong-path undefined instruction (behind a redirect) is ignored.
- Interrupt safe point: ex_valid & ~ex_redirect & ~load_use_stall & ~pc_kernel.
- Trap cycle, Mealy, same cycle as the condition:
  - flush_if_id = flush_id_ex = pc_override = xp_wr = 1.
  - The EX instruction completes normally.
- Exception trap:
  - pc_override_addr = XADR_ADDR, xp_data = id_pc_plus_4.
  - Returns past the illegal instruction.
  - exc_cnt++.
- Interrupt trap:
  - pc_override_addr = ILLOP_ADDR, xp_data = ex_pc_plus_4.
  - The ID instruction re-executes after return.
  - irq_cnt++.
- Transitions:
  - IDLE: exception -> trap, KERNEL. Else irq_q & ~pc_kernel: safe -> trap, KERNEL; not safe -> PEND.
  - PEND: exception -> exception trap, KERNEL; interrupt stays pending. Else safe -> interrupt trap, KERNEL. Else stay.
  - KERNEL: pc_kernel == 0 (handler returned to user) -> IDLE. No traps are issued in KERNEL.
- Priority: exception over interrupt in the same cycle. A pending interrupt is re-evaluated in IDLE after return.
- Counters saturate at all-ones; they never wrap.
- xp_addr is constant XP_REG. pc_override_addr and xp_data are 0 when not trapping.

## Timing
- Reset (synchronous, at clk edge with reset=1): state IDLE, irq_q 0, counters 0, all outputs 0.
- Reset during PEND or KERNEL: returns to IDLE next edge; a pending interrupt is dropped.
- irq_in to earliest trap: 1 cycle (register), then trap in the first safe cycle.
- Exception latency: 0 cycles, combinational in the cycle undef_id is presented.
- Every trap pulse is exactly 1 cycle. No two trap pulses are closer than one full KERNEL residency.
- irq_in deasserted while in PEND: the interrupt remains pending and is still taken.
- The register-file write port must give xp_wr priority over a same-cycle WB write. This is guaranteed by the integrator, not by this block.

## Structure
- Package irq_seq_pkg: state enum (IDLE, PEND, KERNEL), ILLOP/XADR default vectors, XP index.
- Sub-module sat_counter (parameter W; inc, clear, q) instantiated twice for irq_cnt/exc_cnt.
- FSM, safe-point logic and output muxing stay in irq_sequencer.

## Test plan
- Reset: hold reset 2 cycles with irq_in=1 -> all outputs 0, busy 0. After release, trap at cycle 2 if safe.
- Interrupt, safe: ex_valid=1, ex_pc_plus_4=32'h00000040, irq_in rises at cycle 0 -> cycle 1: pc_override_addr=80000004, xp_data=00000040, xp_wr=1, both flushes=1; busy held until pc_kernel 1->0, then IDLE; irq_cnt=1.
- Interrupt deferred: irq at cycle 0 with load_use_stall cycles 1-2, then ex_redirect cycle 3 -> state PEND, no pulse until cycle 4. Trap at cycle 4 with that cycle's ex_pc_plus_4.
- Exception: undef_id=1, id_valid=1, id_pc_plus_4=32'h00000020 -> same cycle pc_override_addr=80000008, xp_data=00000020; exc_cnt=1. Same stimulus with ex_redirect=1 -> no pulse.
- Simultaneous: PEND plus exception in one cycle -> exception trap only. After pc_kernel drops, interrupt trap occurs; irq_cnt=1, exc_cnt=1.
- Masking and saturation: irq_in and undef_id asserted while pc_kernel=1 -> no pulses. With CNT_W=2, 5 traps -> irq_cnt=3.

Source files
------------

// File: rtl/irq_seq_pkg.sv
// irq_seq_pkg
//   Shared types and default constants for the trap sequencer.
//   - state_e : sequencer FSM states
//   - trap_e  : kind of trap issued in the current cycle
//   - default handler vectors and the exception-register index
package irq_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_KERNEL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0,
    TRAP_EXC  = 2'd1,
    TRAP_IRQ  = 2'd2
  } trap_e;

  localparam logic [31:0] ILLOP_ADDR_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR_DEF  = 32'h8000_0008;
  localparam logic [4:0]  XP_REG_DEF     = 5'd26;

endpackage

// File: rtl/irq_sequencer_sat_counter.sv
// sat_counter
//   Saturating up-counter. Stops at all-ones instead of wrapping.
//   Ports:
//     clk   in  clock
//     clear in  synchronous clear (active high)
//     inc   in  increment request for this cycle
//     q     out current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer
//   Trap sequencer for the 5-stage pipeline. Takes an external interrupt
//   (registered once) and the ID-stage illegal-instruction flag, and issues
//   a single-cycle trap at a safe pipeline point: flushes IF/ID and ID/EX,
//   redirects the PC to the handler vector and writes the return address
//   into register XP. Further traps are masked until the fetch PC leaves
//   kernel space (pc_kernel falls).
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     irq_in                     level interrupt request
//     undef_id, id_valid         ID instruction undefined / real
//     id_pc_plus_4               PC+4 of the ID instruction
//     ex_valid, ex_pc_plus_4     EX instruction real / its PC+4
//     ex_redirect                EX taking a branch/jump this cycle
//     load_use_stall             hazard unit stalling this cycle
//     pc_kernel                  PC[31] of the fetch PC
//     flush_if_id, flush_id_ex   squash pipeline registers (trap cycle)
//     pc_override(_addr)         PC redirect and handler vector
//     xp_wr, xp_addr, xp_data    return-address register write
//     busy                       sequencer not idle
//     irq_cnt, exc_cnt           saturating trap counts
module irq_sequencer
  import irq_seq_pkg::*;
#(
  parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
  parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF,
  parameter logic [4:0]  XP_REG     = XP_REG_DEF,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_in,
  input  logic             undef_id,
  input  logic             id_valid,
  input  logic [31:0]      id_pc_plus_4,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc_plus_4,
  input  logic             ex_redirect,
  input  logic             load_use_stall,
  input  logic             pc_kernel,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_override,
  output logic [31:0]      pc_override_addr,
  output logic             xp_wr,
  output logic [4:0]       xp_addr,
  output logic [31:0]      xp_data,
  output logic             busy,
  output logic [CNT_W-1:0] irq_cnt,
  output logic [CNT_W-1:0] exc_cnt
);

  state_e state_q, state_d;
  logic   irq_q;
  // Remembers an interrupt that lost to an exception or had to wait, so it
  // survives the KERNEL residency even if irq_in has since dropped.
  logic   pend_q, pend_d;
  trap_e  trap_kind;

  logic exc_cond;
  logic safe_pt;
  logic irq_req;

  // A wrong-path illegal instruction sits behind an EX redirect and is ignored.
  assign exc_cond = undef_id & id_valid & ~ex_redirect & ~pc_kernel
                    & (state_q != ST_KERNEL);
  assign safe_pt  = ex_valid & ~ex_redirect & ~load_use_stall & ~pc_kernel;
  assign irq_req  = (irq_q | pend_q) & ~pc_kernel;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    trap_kind = TRAP_NONE;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (exc_cond) begin
            trap_kind = TRAP_EXC;
            state_d   = ST_KERNEL;
            pend_d    = pend_q | irq_q;
          end else if (irq_req) begin
            if (safe_pt) begin
              trap_kind = TRAP_IRQ;
              state_d   = ST_KERNEL;
              pend_d    = 1'b0;
            end else begin
              state_d = ST_PEND;
              pend_d  = 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (exc_cond) begin
            trap_kind = TRAP_EXC;
            state_d   = ST_KERNEL;
          end else if (safe_pt) begin
            trap_kind = TRAP_IRQ;
            state_d   = ST_KERNEL;
            pend_d    = 1'b0;
          end
        end
        ST_KERNEL: begin
          if (!pc_kernel) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      irq_q   <= irq_in;
    end
  end

  // Trap outputs are Mealy: asserted in the same cycle the condition holds.
  always_comb begin
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    pc_override      = 1'b0;
    xp_wr            = 1'b0;
    pc_override_addr = 32'h0;
    xp_data          = 32'h0;
    case (trap_kind)
      TRAP_EXC: begin
        flush_if_id      = 1'b1;
        flush_id_ex      = 1'b1;
        pc_override      = 1'b1;
        xp_wr            = 1'b1;
        pc_override_addr = XADR_ADDR;
        xp_data          = id_pc_plus_4;   // resume past the illegal op
      end
      TRAP_IRQ: begin
        flush_if_id      = 1'b1;
        flush_id_ex      = 1'b1;
        pc_override      = 1'b1;
        xp_wr            = 1'b1;
        pc_override_addr = ILLOP_ADDR;
        xp_data          = ex_pc_plus_4;   // ID instruction re-executes
      end
      default: ;
    endcase
  end

  assign xp_addr = XP_REG;
  assign busy    = ~reset & (state_q != ST_IDLE);

  sat_counter #(.W(CNT_W)) u_irq_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (trap_kind == TRAP_IRQ),
    .q     (irq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_exc_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (trap_kind == TRAP_EXC),
    .q     (exc_cnt)
  );

endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          irq_in, undef_id, id_valid, ex_valid, ex_redirect;
  logic          load_use_stall, pc_kernel;
  logic [31:0]   id_pc_plus_4, ex_pc_plus_4;
  logic          flush_if_id, flush_id_ex, pc_override, xp_wr, busy;
  logic [31:0]   pc_override_addr, xp_data;
  logic [4:0]    xp_addr;
  logic [CW-1:0] irq_cnt, exc_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_sequencer #(.CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_in           (irq_in),
    .undef_id         (undef_id),
    .id_valid         (id_valid),
    .id_pc_plus_4     (id_pc_plus_4),
    .ex_valid         (ex_valid),
    .ex_pc_plus_4     (ex_pc_plus_4),
    .ex_redirect      (ex_redirect),
    .load_use_stall   (load_use_stall),
    .pc_kernel        (pc_kernel),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .pc_override      (pc_override),
    .pc_override_addr (pc_override_addr),
    .xp_wr            (xp_wr),
    .xp_addr          (xp_addr),
    .xp_data          (xp_data),
    .busy             (busy),
    .irq_cnt          (irq_cnt),
    .exc_cnt          (exc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every trap-cycle output; addr/data expected 0 when no trap.
  task automatic chk_trap(input string tag, input logic t,
                          input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".pc_override"}, {31'd0, pc_override}, {31'd0, t});
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, t});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, t});
    chk({tag, ".xp_wr"},       {31'd0, xp_wr},       {31'd0, t});
    chk({tag, ".addr"},        pc_override_addr,     addr);
    chk({tag, ".xp_data"},     xp_data,              data);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    irq_in = 0; undef_id = 0; id_valid = 0; ex_valid = 0; ex_redirect = 0;
    load_use_stall = 0; pc_kernel = 0; id_pc_plus_4 = 0; ex_pc_plus_4 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  initial begin
    // ---- reset with irq_in high and a safe pipeline ----
    clear_inputs();
    reset = 1; irq_in = 1; ex_valid = 1; ex_pc_plus_4 = 32'h40;
    settle();
    chk_trap("rst0", 0, 0, 0);
    chk("rst0.busy", {31'd0, busy}, 0);
    cyc();
    chk_trap("rst1", 0, 0, 0);
    chk("rst1.busy", {31'd0, busy}, 0);
    chk("rst1.irq_cnt", {30'd0, irq_cnt}, 0);
    chk("rst1.exc_cnt", {30'd0, exc_cnt}, 0);
    cyc();
    reset = 0;
    settle();
    chk_trap("rel0", 0, 0, 0);           // irq_q still clear
    cyc();
    // ---- safe interrupt: trap one cycle after irq registered ----
    chk_trap("irq_safe", 1, 32'h80000004, 32'h40);
    chk("irq_safe.xp_addr", {27'd0, xp_addr}, 32'd26);
    cyc();
    irq_in = 0; pc_kernel = 1; undef_id = 1; id_valid = 1; id_pc_plus_4 = 32'h99;
    settle();
    chk_trap("mask_k", 0, 0, 0);         // masked in KERNEL
    chk("mask_k.busy", {31'd0, busy}, 1);
    chk("mask_k.irq_cnt", {30'd0, irq_cnt}, 1);
    cyc();
    undef_id = 0; id_valid = 0; pc_kernel = 0;
    settle();
    chk_trap("k_ret", 0, 0, 0);
    chk("k_ret.busy", {31'd0, busy}, 1);
    cyc();
    chk("idle.busy", {31'd0, busy}, 0);
    chk_trap("idle", 0, 0, 0);

    // ---- exception: wrong-path ignored, then taken ----
    do_reset();
    undef_id = 1; id_valid = 1; id_pc_plus_4 = 32'h20; ex_redirect = 1;
    settle();
    chk_trap("exc_wrongpath", 0, 0, 0);
    cyc();
    ex_redirect = 0;
    settle();
    chk_trap("exc", 1, 32'h80000008, 32'h20);
    cyc();
    undef_id = 0; id_valid = 0; pc_kernel = 1;
    settle();
    chk("exc.exc_cnt", {30'd0, exc_cnt}, 1);
    chk("exc.irq_cnt", {30'd0, irq_cnt}, 0);
    chk("exc.busy", {31'd0, busy}, 1);
    pc_kernel = 0;
    cyc();
    cyc();
    chk("exc_ret.busy", {31'd0, busy}, 0);

    // ---- deferred interrupt ----
    do_reset();
    ex_valid = 1; ex_pc_plus_4 = 32'h100; irq_in = 1;
    settle();
    chk_trap("def0", 0, 0, 0);
    cyc();
    load_use_stall = 1;
    settle();
    chk_trap("def1", 0, 0, 0);
    cyc();
    irq_in = 0;                          // dropped while pending
    settle();
    chk_trap("def2", 0, 0, 0);
    chk("def2.busy", {31'd0, busy}, 1);
    cyc();
    load_use_stall = 0; ex_redirect = 1;
    settle();
    chk_trap("def3", 0, 0, 0);
    cyc();
    ex_redirect = 0; ex_pc_plus_4 = 32'h144;
    settle();
    chk_trap("def4", 1, 32'h80000004, 32'h144);
    cyc();
    pc_kernel = 1;
    settle();
    chk("def.irq_cnt", {30'd0, irq_cnt}, 1);
    pc_kernel = 0;
    cyc();
    cyc();
    chk_trap("def_after", 0, 0, 0);
    chk("def_after.busy", {31'd0, busy}, 0);

    // ---- pending interrupt plus exception in one cycle ----
    do_reset();
    ex_valid = 1; load_use_stall = 1; irq_in = 1; ex_pc_plus_4 = 32'h300;
    cyc();
    irq_in = 0;
    cyc();                               // now PEND
    load_use_stall = 0; undef_id = 1; id_valid = 1; id_pc_plus_4 = 32'h200;
    settle();
    chk_trap("sim_exc", 1, 32'h80000008, 32'h200);
    cyc();
    undef_id = 0; id_valid = 0; pc_kernel = 1;
    settle();
    chk_trap("sim_k", 0, 0, 0);
    chk("sim_k.exc_cnt", {30'd0, exc_cnt}, 1);
    chk("sim_k.irq_cnt", {30'd0, irq_cnt}, 0);
    cyc();
    pc_kernel = 0;
    settle();
    chk_trap("sim_kret", 0, 0, 0);
    cyc();
    settle();
    chk_trap("sim_irq", 1, 32'h80000004, 32'h300);
    cyc();
    pc_kernel = 1;
    settle();
    chk("sim.irq_cnt", {30'd0, irq_cnt}, 1);
    chk("sim.exc_cnt", {30'd0, exc_cnt}, 1);
    pc_kernel = 0;
    cyc();
    cyc();

    // ---- reset during PEND drops the interrupt ----
    do_reset();
    ex_valid = 1; load_use_stall = 1; irq_in = 1;
    cyc();
    irq_in = 0;
    cyc();
    settle();
    chk("rpend.busy", {31'd0, busy}, 1);
    reset = 1;
    cyc();
    reset = 0; load_use_stall = 0;
    settle();
    chk_trap("rpend0", 0, 0, 0);
    chk("rpend0.busy", {31'd0, busy}, 0);
    cyc();
    chk_trap("rpend1", 0, 0, 0);

    // ---- saturation with 2-bit counters ----
    do_reset();
    ex_valid = 1; ex_pc_plus_4 = 32'h500;
    for (int i = 0; i < 5; i++) begin
      irq_in = 1;
      settle();
      chk_trap("sat_pre", 0, 0, 0);
      cyc();
      chk_trap("sat_trap", 1, 32'h80000004, 32'h500);
      cyc();
      irq_in = 0; pc_kernel = 1;
      settle();
      chk("sat.irq_cnt", {30'd0, irq_cnt}, (i < 3) ? (i + 1) : 3);
      cyc();
      pc_kernel = 0;
      cyc();
    end
    chk("sat.final", {30'd0, irq_cnt}, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
